// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: CPU memory-port modes, arbiter states
// and owner identifiers.
package sram_arbiter_pkg;

    localparam logic [3:0] IO_NOP = 4'd0;
    localparam logic [3:0] IO_LW  = 4'd1;
    localparam logic [3:0] IO_LB  = 4'd2;
    localparam logic [3:0] IO_SW  = 4'd3;
    localparam logic [3:0] IO_SB  = 4'd4;

    typedef enum logic [2:0] {
        S_ARB_IDLE,
        S_ARB_RD,
        S_ARB_WR_SETUP,
        S_ARB_WR_PULSE,
        S_ARB_WR_HOLD,
        S_ARB_DONE
    } arb_state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_e;

    function automatic logic is_write(input logic [3:0] mode);
        return (mode == IO_SW) || (mode == IO_SB);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: CPU memory port and DMA/debug port.
interface sram_arbiter_if;

    logic [3:0]  cpu_mode;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_ack;

    modport master (
        output cpu_mode, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata,
        input  cpu_rdata, cpu_ready, dma_rdata, dma_ack
    );

    modport slave (
        input  cpu_mode, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata,
        output cpu_rdata, cpu_ready, dma_rdata, dma_ack
    );

endinterface

// File: rtl/sram_arbiter_lane_mux.sv
// Byte-lane handling for a 32-bit SRAM word: SB replicate/byte-enable generation
// and LB extract with sign extension. Purely combinational.
module sram_lane_mux
    import sram_arbiter_pkg::*;
(
    input  logic [3:0]  mode,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be_n,
    output logic [31:0] dout,
    output logic [31:0] rdata
);

    logic [7:0] rbyte;

    always_comb begin
        be_n  = 4'h0;
        dout  = wdata;
        rdata = rword;
        unique case (lane)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        if (mode == IO_SB) begin
            be_n = ~(4'b0001 << lane);
            dout = {4{wdata[7:0]}};
        end
        if (mode == IO_LB) begin
            rdata = {{24{rbyte[7]}}, rbyte};
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the single asynchronous SRAM between the CPU memory port and the DMA
// port, sequencing strobes with programmable wait states. All outputs registered.
//
//   state          | meaning
//   ---------------+---------------------------------------------------------
//   S_ARB_IDLE     | strobes off, sample requests, grant round-robin on tie
//   S_ARB_RD       | ce/oe low for WAIT_CYCLES+1 cycles, capture on last
//   S_ARB_WR_SETUP | ce low, address/data driven ahead of the write pulse
//   S_ARB_WR_PULSE | we low for WAIT_CYCLES+1 cycles
//   S_ARB_WR_HOLD  | we released, address/data still held
//   S_ARB_DONE     | completion pulse to the owner, then back to IDLE
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dout,
    input  logic [31:0]       sram_din,
    output logic              sram_dout_en,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    arb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    owner_e            last_q, last_d;
    owner_e            owner_q, owner_d;
    logic [3:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]       sram_dout_q, sram_dout_d;
    logic              dout_en_q, dout_en_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [3:0]        be_n_q, be_n_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       dma_rdata_q, dma_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              dma_ack_q, dma_ack_d;

    logic              cpu_req;
    logic              grant_cpu;
    logic [3:0]        lane_be_n;
    logic [31:0]       lane_dout;
    logic [31:0]       lane_rdata;
    logic              unused_bits;

    // Lane mux runs on the next-cycle transaction so strobes/data are ready as flops.
    sram_lane_mux u_lane_mux (
        .mode  (mode_d),
        .lane  (lane_d),
        .wdata (wdata_d),
        .rword (sram_din),
        .be_n  (lane_be_n),
        .dout  (lane_dout),
        .rdata (lane_rdata)
    );

    assign unused_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.dma_addr[31:ADDR_W+2],
                           bus.dma_addr[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        mode_d    = mode_q;
        waddr_d   = waddr_q;
        lane_d    = lane_q;
        wdata_d   = wdata_q;
        cpu_req   = (bus.cpu_mode != IO_NOP);
        grant_cpu = cpu_req && (!bus.dma_req || (last_q == OWNER_DMA));

        unique case (state_q)
            S_ARB_IDLE: begin
                if (cpu_req || bus.dma_req) begin
                    if (grant_cpu) begin
                        owner_d = OWNER_CPU;
                        mode_d  = bus.cpu_mode;
                        waddr_d = bus.cpu_addr[ADDR_W+1:2];
                        lane_d  = bus.cpu_addr[1:0];
                        wdata_d = bus.cpu_wdata;
                    end else begin
                        owner_d = OWNER_DMA;
                        mode_d  = bus.dma_we ? IO_SW : IO_LW;
                        waddr_d = bus.dma_addr[ADDR_W+1:2];
                        lane_d  = 2'd0;
                        wdata_d = bus.dma_wdata;
                    end
                    last_d  = owner_d;
                    cnt_d   = WAIT_LOAD;
                    state_d = is_write(mode_d) ? S_ARB_WR_SETUP : S_ARB_RD;
                end
            end
            S_ARB_RD: begin
                if (cnt_q == 4'd0) state_d = S_ARB_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ARB_WR_SETUP: begin
                cnt_d   = WAIT_LOAD;
                state_d = S_ARB_WR_PULSE;
            end
            S_ARB_WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = S_ARB_WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ARB_WR_HOLD: state_d = S_ARB_DONE;
            S_ARB_DONE:    state_d = S_ARB_IDLE;
            default:       state_d = S_ARB_IDLE;
        endcase
    end

    // Output flops are loaded from the state being entered, so pins track the FSM.
    always_comb begin
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        be_n_d      = 4'hF;
        dout_en_d   = 1'b0;
        cpu_ready_d = 1'b0;
        dma_ack_d   = 1'b0;
        sram_addr_d = waddr_d;
        sram_dout_d = lane_dout;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        unique case (state_d)
            S_ARB_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 4'h0;
            end
            S_ARB_WR_SETUP, S_ARB_WR_HOLD: begin
                ce_n_d    = 1'b0;
                dout_en_d = 1'b1;
                be_n_d    = lane_be_n;
            end
            S_ARB_WR_PULSE: begin
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                dout_en_d = 1'b1;
                be_n_d    = lane_be_n;
            end
            S_ARB_DONE: begin
                cpu_ready_d = (owner_q == OWNER_CPU);
                dma_ack_d   = (owner_q == OWNER_DMA);
            end
            default: ;
        endcase

        if ((state_q == S_ARB_RD) && (cnt_q == 4'd0)) begin
            if (owner_q == OWNER_CPU) cpu_rdata_d = lane_rdata;
            else                      dma_rdata_d = sram_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ARB_IDLE;
            cnt_q       <= 4'd0;
            last_q      <= OWNER_DMA;
            owner_q     <= OWNER_CPU;
            mode_q      <= IO_NOP;
            waddr_q     <= '0;
            lane_q      <= 2'd0;
            wdata_q     <= 32'd0;
            sram_addr_q <= '0;
            sram_dout_q <= 32'd0;
            dout_en_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'hF;
            cpu_rdata_q <= 32'd0;
            dma_rdata_q <= 32'd0;
            cpu_ready_q <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            mode_q      <= mode_d;
            waddr_q     <= waddr_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            sram_addr_q <= sram_addr_d;
            sram_dout_q <= sram_dout_d;
            dout_en_q   <= dout_en_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

    assign sram_addr     = sram_addr_q;
    assign sram_dout     = sram_dout_q;
    assign sram_dout_en  = dout_en_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_be_n     = be_n_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: transaction-level reference model predicts
// service order, completion cycle and read data; a monitor checks each pulse.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int W  = 1;
    localparam int AW = 20;

    typedef struct {
        logic [3:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
    } job_t;

    typedef struct {
        bit          dma;
        logic [31:0] cpu_r;
        logic [31:0] dma_r;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if bus();
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_dout, sram_din;
    logic          sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]    sram_be_n;

    sram_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .sram_addr    (sram_addr),
        .sram_dout    (sram_dout),
        .sram_din     (sram_din),
        .sram_dout_en (sram_dout_en),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_be_n    (sram_be_n)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] sram_mem [0:63];
    logic [31:0] ref_mem  [0:63];
    bit          m_last_dma = 1'b1;
    logic [31:0] m_cpu_r = 32'd0;
    logic [31:0] m_dma_r = 32'd0;
    job_t        cpu_jobs[$];
    job_t        dma_jobs[$];
    exp_t        sb_q[$];

    int            oe_cnt = 0, we_cnt = 0;
    logic [3:0]    wr_be = 4'hF;
    logic [31:0]   wr_dout = 32'd0;
    logic [AW-1:0] pin_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous SRAM model; undriven bus reads back a poison pattern.
    assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[5:0]] : 32'hBAD0_BAD0;
    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n && sram_dout_en)
            for (int i = 0; i < 4; i++)
                if (!sram_be_n[i]) sram_mem[sram_addr[5:0]][8*i +: 8] <= sram_dout[8*i +: 8];

    always @(negedge clk) begin
        if (!sram_oe_n) begin
            oe_cnt   <= oe_cnt + 1;
            pin_addr <= sram_addr;
        end
        if (!sram_we_n) begin
            we_cnt   <= we_cnt + 1;
            wr_be    <= sram_be_n;
            wr_dout  <= sram_dout;
            pin_addr <= sram_addr;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.cpu_ready || bus.dma_ack)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.cpu_ready, bus.dma_ack}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("owner_pulse", {30'd0, bus.cpu_ready, bus.dma_ack}, e.dma ? 32'd1 : 32'd2);
                chk("done_cycle", 32'(cyc), 32'(e.at));
                chk("cpu_rdata", bus.cpu_rdata, e.cpu_r);
                chk("dma_rdata", bus.dma_rdata, e.dma_r);
            end
        end
    end

    // Reference: apply one transaction to the word-level memory image.
    task automatic model_apply(input job_t j, input bit is_dma, output bit wr);
        int          w;
        logic [1:0]  lo;
        logic [31:0] t;
        w  = int'(j.addr[7:2]);
        lo = j.addr[1:0];
        wr = (j.mode == IO_SW) || (j.mode == IO_SB);
        case (j.mode)
            IO_SW: ref_mem[w] = j.wdata;
            IO_SB: ref_mem[w][8*lo +: 8] = j.wdata[7:0];
            IO_LB: begin
                t = ref_mem[w] >> (8 * lo);
                m_cpu_r = {{24{t[7]}}, t[7:0]};
            end
            default: begin
                if (is_dma) m_dma_r = ref_mem[w];
                else        m_cpu_r = ref_mem[w];
            end
        endcase
    endtask

    task automatic run_scn();
        int   t0, prev, ci, di, lat;
        bit   pick_cpu, wr;
        job_t j;
        exp_t e;
        @(posedge clk);
        #1;
        t0 = cyc; prev = 0; ci = 0; di = 0;
        while (ci < cpu_jobs.size() || di < dma_jobs.size()) begin
            if (ci < cpu_jobs.size() && di < dma_jobs.size()) pick_cpu = m_last_dma;
            else                                               pick_cpu = (ci < cpu_jobs.size());
            if (pick_cpu) begin j = cpu_jobs[ci]; ci++; end
            else          begin j = dma_jobs[di]; di++; end
            model_apply(j, !pick_cpu, wr);
            lat   = wr ? W + 4 : W + 2;
            e.at  = (ci + di == 1) ? t0 + lat : prev + 1 + lat;
            e.dma = !pick_cpu;
            e.cpu_r = m_cpu_r;
            e.dma_r = m_dma_r;
            prev = e.at;
            m_last_dma = !pick_cpu;
            sb_q.push_back(e);
        end
        fork
            begin
                for (int k = 0; k < cpu_jobs.size(); k++) begin
                    int n;
                    bus.cpu_mode  = cpu_jobs[k].mode;
                    bus.cpu_addr  = cpu_jobs[k].addr;
                    bus.cpu_wdata = cpu_jobs[k].wdata;
                    n = 0;
                    do begin @(negedge clk); n++; end while (!bus.cpu_ready && n < 100);
                    if (!bus.cpu_ready) begin
                        n_cmp++; n_bad++;
                        $display("FAIL cpu_timeout: no cpu_ready within %0d cycles", n);
                    end
                    @(posedge clk);
                    #1;
                end
                bus.cpu_mode = IO_NOP;
            end
            begin
                for (int k = 0; k < dma_jobs.size(); k++) begin
                    int n;
                    bus.dma_req   = 1'b1;
                    bus.dma_we    = (dma_jobs[k].mode == IO_SW);
                    bus.dma_addr  = dma_jobs[k].addr;
                    bus.dma_wdata = dma_jobs[k].wdata;
                    n = 0;
                    do begin @(negedge clk); n++; end while (!bus.dma_ack && n < 100);
                    if (!bus.dma_ack) begin
                        n_cmp++; n_bad++;
                        $display("FAIL dma_timeout: no dma_ack within %0d cycles", n);
                    end
                    @(posedge clk);
                    #1;
                end
                bus.dma_req = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        cpu_jobs.delete();
        dma_jobs.delete();
    endtask

    task automatic add_cpu(input logic [3:0] mode, input logic [31:0] addr, input logic [31:0] wdata);
        job_t j;
        j.mode = mode; j.addr = addr; j.wdata = wdata;
        cpu_jobs.push_back(j);
    endtask

    task automatic add_dma(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        job_t j;
        j.mode = we ? IO_SW : IO_LW; j.addr = addr; j.wdata = wdata;
        dma_jobs.push_back(j);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int          oe0, we0, nc, nd;
        logic [31:0] v, a;
        logic [3:0]  modes [4];
        modes[0] = IO_LW; modes[1] = IO_LB; modes[2] = IO_SW; modes[3] = IO_SB;
        bus.cpu_mode = IO_NOP; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 32'd0; bus.dma_wdata = 32'd0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom();
            ref_mem[i]  = v;
            sram_mem[i] <= v;
        end
        ref_mem[4]  = 32'hDEADBEEF;
        sram_mem[4] <= 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, 1'b0}, 32'h1C);
        chk("rst_be_n", {28'd0, sram_be_n}, 32'hF);
        chk("rst_sram_addr", {12'd0, sram_addr}, 32'd0);
        chk("rst_sram_dout", sram_dout, 32'd0);
        chk("rst_rdata", bus.cpu_rdata | bus.dma_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_no_pulse", {30'd0, bus.cpu_ready, bus.dma_ack}, 32'd0);
        end

        // Tie straight after reset: CPU first, then strict alternation.
        for (int i = 0; i < 3; i++) begin
            add_cpu(IO_LW, 32'(4 * (20 + i)), 32'd0);
            add_dma(1'b0, 32'(4 * (30 + i)), 32'd0);
        end
        run_scn();

        oe0 = oe_cnt;
        add_cpu(IO_LW, 32'h0000_0010, 32'd0);
        run_scn();
        chk("lw_oe_cycles", 32'(oe_cnt - oe0), 32'(W + 1));
        chk("lw_sram_addr", {12'd0, pin_addr}, 32'd4);
        chk("lw_rdata", bus.cpu_rdata, 32'hDEADBEEF);

        we0 = we_cnt;
        add_cpu(IO_SB, 32'h0000_0013, 32'h0000_00A5);
        run_scn();
        chk("sb_we_cycles", 32'(we_cnt - we0), 32'(W + 1));
        chk("sb_be_n", {28'd0, wr_be}, 32'h7);
        chk("sb_dout", wr_dout, 32'hA5A5A5A5);

        add_cpu(IO_SW, 32'h0000_0010, 32'h1280_7F00);
        add_cpu(IO_LB, 32'h0000_0012, 32'd0);
        run_scn();
        chk("lb_neg", bus.cpu_rdata, 32'hFFFFFF80);
        add_cpu(IO_LB, 32'h0000_0011, 32'd0);
        run_scn();
        chk("lb_pos", bus.cpu_rdata, 32'h0000007F);

        add_dma(1'b0, 32'h0000_0024, 32'd0);
        add_dma(1'b1, 32'h0000_001C, 32'h55AA55AA);
        run_scn();
        add_cpu(IO_LW, 32'h0000_001C, 32'd0);
        run_scn();
        chk("dma_then_cpu", bus.cpu_rdata, 32'h55AA55AA);
        chk("dma_rdata_kept", bus.dma_rdata, ref_mem[9]);

        // Reset during the write pulse; the store rewrites the current word value.
        @(posedge clk);
        #1;
        bus.cpu_mode = IO_SW; bus.cpu_addr = 32'h20; bus.cpu_wdata = ref_mem[8];
        @(posedge clk);
        #1;
        bus.cpu_mode = IO_NOP;
        @(posedge clk);
        @(negedge clk);
        chk("pulse_we_low", {31'd0, sram_we_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", {29'd0, sram_we_n, sram_ce_n, sram_dout_en}, 32'h6);
        m_last_dma = 1'b1; m_cpu_r = 32'd0; m_dma_r = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_pulse", {30'd0, bus.cpu_ready, bus.dma_ack}, 32'd0);
        end

        for (int s = 0; s < 15; s++) begin
            nc = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            for (int k = 0; k < nc; k++) begin
                a = $urandom() & 32'hFFC0_00FF;
                add_cpu(modes[$urandom_range(0, 3)], a, $urandom());
            end
            for (int k = 0; k < nd; k++) begin
                a = $urandom() & 32'hFFC0_00FF;
                add_dma(1'($urandom_range(0, 1)), a, $urandom());
            end
            run_scn();
        end

        for (int i = 0; i < 64; i++) chk("mem_word", sram_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
